// File: rtl/audio_mix_pkg.sv
// Shared definitions for the audio_mix_out mixer: FSM state encoding, a
// constant clog2 helper and the derived accumulator / shift widths.
package audio_mix_pkg;

    // Frame sequencer states
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAccum = 3'd1;
    localparam logic [2:0] StSat   = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while (result < 32 && (64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Accumulator width: product width plus enough headroom that the sum never wraps
    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned gain_w,
                                              input int unsigned num_ch);
        return in_w + gain_w + 1 + clog2(num_ch);
    endfunction

    // Left shift that aligns the full-scale product with the top of the DAC word
    function automatic int unsigned shift_amt(input int unsigned out_w, input int unsigned in_w,
                                              input int unsigned gain_w);
        return out_w - in_w - gain_w;
    endfunction

    // Values for the default configuration (4 voices, 16-bit in, 4-bit gain, 32-bit out)
    localparam int unsigned ACC_W = acc_width(16, 4, 4);
    localparam int unsigned SHIFT = shift_amt(32, 16, 4);

endpackage

// File: rtl/audio_mix_out_if.sv
// Bus between the voice sources / Audio_Controller and the audio_mix_out mixer.
// Optional macro AUDIO_MIX_PAN_EN adds per-channel left/right enables.
interface audio_mix_out_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned GAIN_W = 4,
    parameter int unsigned OUT_W  = 32
);
    logic [NUM_CH*IN_W-1:0]   ch_data;
    logic [NUM_CH*GAIN_W-1:0] ch_gain;
    logic [NUM_CH-1:0]        ch_mute;
`ifdef AUDIO_MIX_PAN_EN
    logic [NUM_CH-1:0]        ch_left_en;
    logic [NUM_CH-1:0]        ch_right_en;
`endif
    logic                     ovf_clr;
    logic                     audio_out_allowed;
    logic                     write_audio_out;
    logic [OUT_W-1:0]         left_channel_audio_out;
    logic [OUT_W-1:0]         right_channel_audio_out;
    logic                     busy;
    logic                     overflow;

    // Sources and DAC controller side
    modport master (
`ifdef AUDIO_MIX_PAN_EN
        output ch_left_en, ch_right_en,
`endif
        output ch_data, ch_gain, ch_mute, ovf_clr, audio_out_allowed,
        input  write_audio_out, left_channel_audio_out, right_channel_audio_out, busy, overflow
    );

    // Mixer side
    modport slave (
`ifdef AUDIO_MIX_PAN_EN
        input  ch_left_en, ch_right_en,
`endif
        input  ch_data, ch_gain, ch_mute, ovf_clr, audio_out_allowed,
        output write_audio_out, left_channel_audio_out, right_channel_audio_out, busy, overflow
    );
endinterface

// File: rtl/audio_mix_sat.sv
// Combinational shift-and-saturate from the mixer accumulator to the DAC word.
module audio_mix_sat #(
    parameter int unsigned ACC_W = 23,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHIFT = 12
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0]        o_value,
    output logic                    o_sat
);
    // The shifted value is kept at full width so the range check sees every bit
    localparam int unsigned EXT_W = ACC_W + SHIFT;
    localparam int unsigned TOP_W = EXT_W - OUT_W + 1;

    logic signed [EXT_W-1:0] w_ext;
    logic [TOP_W-1:0]        w_top;

    assign w_ext = EXT_W'(i_acc) <<< SHIFT;
    // Fits in OUT_W signed bits only if the sign bit and everything above agree
    assign w_top = w_ext[EXT_W-1:OUT_W-1];

    // Clamp to the most positive / most negative DAC word on overflow
    always_comb begin
        o_sat   = !((&w_top) || !(|w_top));
        o_value = w_ext[OUT_W-1:0];
        if (o_sat) begin
            o_value = w_ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/audio_mix_out.sv
// N-channel gain/mute mixer feeding the Audio_Controller DAC write port.
// One channel is accumulated per cycle; each frame is saturated and written once.
// Optional macro AUDIO_MIX_PAN_EN enables independent left/right accumulation.
module audio_mix_out
    import audio_mix_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned GAIN_W = 4,
    parameter int unsigned OUT_W  = 32
) (
    input logic            CLOCK_50,
    input logic            reset,
    audio_mix_out_if.slave io_bus
);
    localparam int unsigned ACC_WIDTH = acc_width(IN_W, GAIN_W, NUM_CH);
    localparam int unsigned SHIFT_AMT = shift_amt(OUT_W, IN_W, GAIN_W);
    localparam int unsigned PROD_W    = IN_W + GAIN_W + 1;
    localparam int unsigned IDX_W     = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_next;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_CH*IN_W-1:0]      r_data;
    logic [NUM_CH*GAIN_W-1:0]    r_gain;
    logic [NUM_CH*GAIN_W-1:0]    w_eff_gain;
    logic signed [IN_W-1:0]      w_sample;
    logic [GAIN_W-1:0]           w_gain_sel;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [PROD_W-1:0]    w_prod_l;
    logic signed [ACC_WIDTH-1:0] r_acc_l;
    logic [OUT_W-1:0]            w_sat_left;
    logic [OUT_W-1:0]            w_sat_right;
    logic                        w_ovf_left;
    logic                        w_sat_any;
    logic [OUT_W-1:0]            r_left;
    logic [OUT_W-1:0]            r_right;
    logic                        r_ovf;

    // Frame sequencer next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  w_state_next = StAccum;
            StAccum: if (r_idx == LAST_IDX) w_state_next = StSat;
            StSat:   w_state_next = StWait;
            StWait:  if (io_bus.audio_out_allowed) w_state_next = StWrite;
            StWrite: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State and channel index
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StAccum && r_idx != LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    // Mute folds into the gain at snapshot time, so ACCUM only sees effective gains
    always_comb begin
        w_eff_gain = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!io_bus.ch_mute[k]) begin
                w_eff_gain[k*GAIN_W +: GAIN_W] = io_bus.ch_gain[k*GAIN_W +: GAIN_W];
            end
        end
    end

    // Snapshot all frame inputs when leaving IDLE so the frame is coherent
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_gain <= '0;
        end else if (r_state == StIdle) begin
            r_data <= io_bus.ch_data;
            r_gain <= w_eff_gain;
        end
    end

    // Signed sample times zero-extended gain for the current channel
    assign w_sample   = r_data[r_idx*IN_W +: IN_W];
    assign w_gain_sel = r_gain[r_idx*GAIN_W +: GAIN_W];
    assign w_prod     = PROD_W'(w_sample) * PROD_W'($signed({1'b0, w_gain_sel}));

`ifdef AUDIO_MIX_PAN_EN
    logic [NUM_CH-1:0]           r_left_en;
    logic [NUM_CH-1:0]           r_right_en;
    logic signed [PROD_W-1:0]    w_prod_r;
    logic signed [ACC_WIDTH-1:0] r_acc_r;
    logic                        w_ovf_right;

    // Pan enables are part of the frame snapshot
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_left_en  <= '0;
            r_right_en <= '0;
        end else if (r_state == StIdle) begin
            r_left_en  <= io_bus.ch_left_en;
            r_right_en <= io_bus.ch_right_en;
        end
    end

    assign w_prod_l = r_left_en[r_idx]  ? w_prod : '0;
    assign w_prod_r = r_right_en[r_idx] ? w_prod : '0;

    // Right-side accumulator, cleared at the start of every frame
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_acc_r <= '0;
        end else if (r_state == StIdle) begin
            r_acc_r <= '0;
        end else if (r_state == StAccum) begin
            r_acc_r <= r_acc_r + ACC_WIDTH'(w_prod_r);
        end
    end

    audio_mix_sat #(
        .ACC_W (ACC_WIDTH),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT_AMT)
    ) u_sat_right (
        .i_acc   (r_acc_r),
        .o_value (w_sat_right),
        .o_sat   (w_ovf_right)
    );

    assign w_sat_any = w_ovf_left | w_ovf_right;
`else
    assign w_prod_l    = w_prod;
    assign w_sat_right = w_sat_left;
    assign w_sat_any   = w_ovf_left;
`endif

    // Left (or mono) accumulator, cleared at the start of every frame
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_acc_l <= '0;
        end else if (r_state == StIdle) begin
            r_acc_l <= '0;
        end else if (r_state == StAccum) begin
            r_acc_l <= r_acc_l + ACC_WIDTH'(w_prod_l);
        end
    end

    audio_mix_sat #(
        .ACC_W (ACC_WIDTH),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT_AMT)
    ) u_sat_left (
        .i_acc   (r_acc_l),
        .o_value (w_sat_left),
        .o_sat   (w_ovf_left)
    );

    // Output words load only in SAT and hold through WAIT and WRITE
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_left  <= '0;
            r_right <= '0;
        end else if (r_state == StSat) begin
            r_left  <= w_sat_left;
            r_right <= w_sat_right;
        end
    end

    // Sticky overflow; a saturation in the same cycle as a clear wins
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == StSat && w_sat_any) begin
            r_ovf <= 1'b1;
        end else if (io_bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign io_bus.write_audio_out         = (r_state == StWrite);
    assign io_bus.busy                    = (r_state != StIdle);
    assign io_bus.overflow                = r_ovf;
    assign io_bus.left_channel_audio_out  = r_left;
    assign io_bus.right_channel_audio_out = r_right;
endmodule

// File: tb/tb_audio_mix_out.sv
// Scoreboard bench for audio_mix_out: a driver pushes the frame-level expected
// mix into a queue, a monitor pops and compares on every write strobe.
module tb_audio_mix_out;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned IN_W       = 16;
    localparam int unsigned GAIN_W     = 4;
    localparam int unsigned OUT_W      = 32;
    localparam int unsigned SHIFT      = OUT_W - IN_W - GAIN_W;
    localparam int          FIFO_DEPTH = 2;

    typedef struct {
        longint left;
        longint right;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_off = 1'b0;
    int   fifo_cnt;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   model_ovf = 1'b0;
    exp_t exp_q[$];

    int   fd[NUM_CH];
    int   fg[NUM_CH];
    bit   fm[NUM_CH];
    bit   fle[NUM_CH];
    bit   fre[NUM_CH];

    always #5 clk = ~clk;

    audio_mix_out_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();

    audio_mix_out #(
        .NUM_CH (NUM_CH),
        .IN_W   (IN_W),
        .GAIN_W (GAIN_W),
        .OUT_W  (OUT_W)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .io_bus   (bus)
    );

    // DAC FIFO model: space is consumed by writes and drains at a random rate
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= 0;
        end else begin
            fifo_cnt <= fifo_cnt + (bus.write_audio_out ? 1 : 0)
                      - ((fifo_cnt > 0 && (hold_off || $urandom_range(0, 7) == 0)) ? 1 : 0);
        end
    end
    assign bus.audio_out_allowed = !hold_off && (fifo_cnt < FIFO_DEPTH);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat_model(input longint sum, output bit hit);
        longint v;
        longint hi;
        longint lo;
        v   = sum * (longint'(1) << SHIFT);
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        lo  = -(longint'(1) << (OUT_W - 1));
        hit = 1'b0;
        if (v > hi) begin
            hit = 1'b1;
            return hi;
        end
        if (v < lo) begin
            hit = 1'b1;
            return lo;
        end
        return v;
    endfunction

    task automatic fill(input int d, input int g, input bit m);
        for (int k = 0; k < NUM_CH; k++) begin
            fd[k] = d; fg[k] = g; fm[k] = m; fle[k] = 1'b1; fre[k] = 1'b1;
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_data[k*IN_W +: IN_W]     = fd[k][IN_W-1:0];
            bus.ch_gain[k*GAIN_W +: GAIN_W] = fg[k][GAIN_W-1:0];
            bus.ch_mute[k]                  = fm[k];
`ifdef AUDIO_MIX_PAN_EN
            bus.ch_left_en[k]               = fle[k];
            bus.ch_right_en[k]              = fre[k];
`endif
        end
    endtask

    // Garbage on the inputs once the frame is captured must not matter
    task automatic scramble();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_data[k*IN_W +: IN_W]     = IN_W'($urandom);
            bus.ch_gain[k*GAIN_W +: GAIN_W] = GAIN_W'($urandom);
            bus.ch_mute[k]                  = 1'($urandom);
`ifdef AUDIO_MIX_PAN_EN
            bus.ch_left_en[k]               = 1'($urandom);
            bus.ch_right_en[k]              = 1'($urandom);
`endif
        end
    endtask

    task automatic push_expected(input bit clr);
        longint sl = 0;
        longint sr = 0;
        longint p;
        bit     hl;
        bit     hr;
        exp_t   e;
        for (int k = 0; k < NUM_CH; k++) begin
            p = longint'(fd[k]) * (fm[k] ? 0 : fg[k]);
`ifdef AUDIO_MIX_PAN_EN
            if (fle[k]) sl += p;
            if (fre[k]) sr += p;
`else
            sl += p;
            sr += p;
`endif
        end
        e.left    = sat_model(sl, hl);
        e.right   = sat_model(sr, hr);
        model_ovf = (clr ? 1'b0 : model_ovf) | hl | hr;
        e.ovf     = model_ovf;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_write"}, 64'(bus.write_audio_out), 0);
        check({tag, "_busy"}, 64'(bus.busy), 0);
        check({tag, "_overflow"}, 64'(bus.overflow), 0);
        check({tag, "_left"}, 64'(bus.left_channel_audio_out), 0);
        check({tag, "_right"}, 64'(bus.right_channel_audio_out), 0);
    endtask

    // Runs one frame from a write strobe (or from reset release when first=1)
    // up to and including the next write strobe.
    task automatic apply_frame(input bit first, input bit clr, input bit hold);
        int   lead;
        int   waited;
        bit   ok;
        logic [OUT_W-1:0] cap_l;
        logic [OUT_W-1:0] cap_r;
        lead   = first ? 1 : 2;
        waited = 0;
        drive_inputs();
        push_expected(clr);
        if (first) rst = 1'b0;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            waited++;
            if (hold && i == 0) hold_off = 1'b1;
        end
        scramble();
        if (clr) bus.ovf_clr = 1'b1;
        repeat (NUM_CH + 1) begin
            @(negedge clk);
            waited++;
        end
        bus.ovf_clr = 1'b0;
        if (hold) begin
            cap_l = bus.left_channel_audio_out;
            cap_r = bus.right_channel_audio_out;
            ok    = 1'b1;
            repeat (50) begin
                @(negedge clk);
                waited++;
                if (bus.write_audio_out || !bus.busy || bus.left_channel_audio_out !== cap_l ||
                    bus.right_channel_audio_out !== cap_r) ok = 1'b0;
            end
            check("hold_wait_stable", 64'(ok), 1);
            hold_off = 1'b0;
            @(negedge clk);
            waited++;
            check("hold_release_write", 64'(bus.write_audio_out), 1);
        end
        while (!bus.write_audio_out && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.write_audio_out) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_timeout: no write after %0d cycles, expected one", waited);
        end else if (first) begin
            check("first_write_cycle", 64'(waited + 1), 64'(NUM_CH + 4));
        end
    endtask

    // Monitor: every write strobe is checked against the head of the scoreboard
    initial begin
        int   cyc;
        int   last_wr;
        bit   prev_wr;
        exp_t e;
        cyc     = 0;
        last_wr = -1;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                last_wr = -1;
                prev_wr = 1'b0;
            end else if (bus.write_audio_out) begin
                check("write_allowed", 64'(bus.audio_out_allowed), 1);
                check("write_single_cycle", 64'(prev_wr), 0);
                if (last_wr >= 0) check("write_interval", 64'(cyc - last_wr >= NUM_CH + 4), 1);
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: write with empty scoreboard at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("left", 64'($signed(bus.left_channel_audio_out)), e.left);
                    check("right", 64'($signed(bus.right_channel_audio_out)), e.right);
                    check("overflow", 64'(bus.overflow), 64'(e.ovf));
                end
                prev_wr = 1'b1;
            end else begin
                prev_wr = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ovf_clr = 1'b0;
        fill(0, 0, 1'b0);
        drive_inputs();
        repeat (3) @(negedge clk);
        check_reset_state("por");

        // Abort a frame mid-ACCUM; it must never be written
        scramble();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_mid_frame", 64'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        @(negedge clk);
        model_ovf = 1'b0;

        // Single channel at unity gain, rest muted
        fill(int'($urandom_range(0, 65535)) - 32768, 15, 1'b1);
        fd[0] = 1000; fg[0] = 1; fm[0] = 1'b0;
        apply_frame(1'b1, 1'b0, 1'b0);

        // Full-scale single channel, just below saturation
        fill(0, int'($urandom_range(0, 15)), 1'b0);
        fd[0] = 32767; fg[0] = 15;
        apply_frame(1'b0, 1'b0, 1'b0);

        // Positive and negative saturation
        fill(32767, 15, 1'b0);
        apply_frame(1'b0, 1'b0, 1'b0);
        fill(-32768, 15, 1'b0);
        apply_frame(1'b0, 1'b0, 1'b0);

        // Clear overflow during a non-saturating frame
        fill(-7, 9, 1'b1);
        fd[0] = 5; fg[0] = 3; fm[0] = 1'b0;
        apply_frame(1'b0, 1'b1, 1'b0);

        // Opposite-signed channels, possibly panned to separate sides
        fill(0, 0, 1'b1);
        fd[0] = 1000;  fg[0] = 1; fm[0] = 1'b0; fre[0] = 1'b0;
        fd[1] = -1000; fg[1] = 1; fm[1] = 1'b0; fle[1] = 1'b0;
        apply_frame(1'b0, 1'b0, 1'b0);

        // Long back-pressure from the DAC
        for (int k = 0; k < NUM_CH; k++) begin
            fd[k] = int'($urandom_range(0, 65535)) - 32768;
            fg[k] = int'($urandom_range(0, 15));
            fm[k] = 1'b0; fle[k] = 1'b1; fre[k] = 1'b1;
        end
        apply_frame(1'b0, 1'b0, 1'b1);

        // Randomised frames
        for (int f = 0; f < 150; f++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                fd[k] = int'($urandom_range(0, 65535)) - 32768;
                if (f % 3 == 0) fd[k] = fd[k] / 16;
                fg[k]  = int'($urandom_range(0, 15));
                fm[k]  = ($urandom_range(0, 4) == 0);
                fle[k] = 1'($urandom);
                fre[k] = 1'($urandom);
            end
            apply_frame(1'b0, ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/audio_mix_out.md
Name: audio_mix_out

Overview:
- Parametrised N-channel audio output mixer that drives the Audio_Controller DAC interface (left/right_channel_audio_out, write_audio_out, audio_out_allowed).
- Applies per-channel gain and mute, then sums the channels with a time-multiplexed accumulator (one channel per cycle).
- Saturates the sum to the DAC word width and issues one write per mixed frame, gated by audio_out_allowed.
- Sits between the sound-generation modules and Audio_Controller. It replaces the direct mono mix_down connection.

Parameters:
- NUM_CH, 4: number of input voices (≥1).
- IN_W, 16: signed sample width per channel.
- GAIN_W, 4: unsigned gain width. Gain 0 is silence; gain 2^GAIN_W-1 is maximum.
- OUT_W, 32: signed DAC word width. Must satisfy OUT_W ≥ IN_W+GAIN_W.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_data  in  NUM_CH*IN_W  packed signed samples; channel k occupies [k*IN_W +: IN_W].
- ch_gain  in  NUM_CH*GAIN_W  packed unsigned gains.
- ch_mute  in  NUM_CH  1 forces that channel's gain to 0.
- ovf_clr  in  1  clears the overflow flag.
- audio_out_allowed  in  1  from Audio_Controller; 1 means the DAC FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller.
- left_channel_audio_out  out  OUT_W  mixed left sample.
- right_channel_audio_out  out  OUT_W  mixed right sample.
- busy  out  1  high whenever state ≠ IDLE.
- overflow  out  1  sticky; set when any frame saturates.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, channel index = 0, accumulator = 0.
  - write_audio_out = 0, both outputs = 0, busy = 0, overflow = 0.
  - Asserting reset mid-frame aborts the frame; no write is issued for it.
- State machine:
  - IDLE → ACCUM unconditionally on the next cycle after reset is released. On that transition all ch_data/ch_gain/ch_mute are snapshotted into internal registers, so the frame is coherent.
  - ACCUM: each cycle adds product(k) for k = 0..NUM_CH-1; after the last channel → SAT.
  - SAT: one cycle; shifts, saturates, and loads the output registers → WAIT.
  - WAIT: stays while audio_out_allowed = 0. When audio_out_allowed = 1 → WRITE.
  - WRITE: write_audio_out = 1 for exactly this cycle → IDLE.
- Frame timing:
  - Minimum interval between write strobes is NUM_CH+4 cycles.
  - write_audio_out is never asserted while audio_out_allowed = 0.
  - Output registers change only in SAT and hold stable through WAIT and WRITE.
- Arithmetic:
  - Effective gain g = ch_mute[k] ? 0 : ch_gain[k].
  - product = signed sample × zero-extended g, IN_W+GAIN_W+1 bits signed.
  - Accumulator width ACC_W = IN_W+GAIN_W+1+clog2(NUM_CH), so the sum can never wrap.
  - SAT output: value = acc <<< (OUT_W−IN_W−GAIN_W), evaluated at full width.
    - value > 2^(OUT_W−1)−1 clamps to 0x7FFF_FFFF (for OUT_W = 32).
    - value < −2^(OUT_W−1) clamps to 0x8000_0000.
    - Either clamp sets overflow.
- Mono default: left and right outputs are identical.
- overflow control:
  - ovf_clr = 1 clears overflow.
  - If a saturation happens in the same cycle as ovf_clr, set wins.
- Input changes during ACCUM, SAT, WAIT or WRITE have no effect until the next IDLE snapshot.

Optional Feature:
- Macro: AUDIO_MIX_PAN_EN.
- When defined:
  - Adds input ports ch_left_en [NUM_CH] and ch_right_en [NUM_CH], snapshotted with the rest of the frame inputs.
  - Two accumulators run in parallel. A channel contributes to left only if ch_left_en[k] = 1, and to right only if ch_right_en[k] = 1.
  - Each side saturates independently; either side saturating sets overflow.
- When undefined: single accumulator; both outputs carry the same value; no extra ports.

Decomposition:
- Package audio_mix_pkg holds:
  - the state encoding (IDLE, ACCUM, SAT, WAIT, WRITE);
  - the clog2 function;
  - the derived constants ACC_W and SHIFT = OUT_W−IN_W−GAIN_W.
- One sub-module, audio_mix_sat: combinational shift-and-saturate from ACC_W to OUT_W with an overflow output. It is instantiated once, or twice when AUDIO_MIX_PAN_EN is defined.

Test Plan:
- Reset mid-ACCUM, then release → no write for the aborted frame; next write occurs NUM_CH+4 = 8 cycles after release with audio_out_allowed = 1.
- ch0 = 1000, gain 1; others muted → both outputs = 4,096,000 (1000<<12); overflow = 0.
- ch0 = 32767, gain 15; others 0 → output = 2,013,204,480; no saturation.
- All four channels = 32767, gain 15 → output = 0x7FFF_FFFF and overflow = 1. All four = −32768, gain 15 → 0x8000_0000. Pulse ovf_clr → overflow = 0.
- Hold audio_out_allowed = 0 for 50 cycles → machine sits in WAIT, outputs stable, no write. Raise it → exactly one write_audio_out pulse on the next cycle.
- With AUDIO_MIX_PAN_EN: ch0 = 1000 gain 1 left only; ch1 = −1000 gain 1 right only → left = 4,096,000, right = −4,096,000.
